memc_line_copy: RTL and testbench
=================================

# memc_line_copy

Line-copy engine that sits behind the core's cache-memory-controller interface, on the controller side of `IF_MemC.CON`. It accepts one copy command at a time and moves a cache line of `LINE_WORDS` 32-bit words between a cache SRAM and external memory over `IF_Mem.HOST`:
- writeback when `we=1`: cache to external.
- fill when `we=0`: external to cache.

It reports per-word `progress` and `busy` back to the core.

## Interface
- `LINE_WORDS`, default 4: words per transfer, 1..1023.
- `clk` input 1: single clock; all state on rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `memc` modport `IF_MemC.CON`, command side:
  - inputs: `ce`, `we`, `cacheID[0:0]`, `sramAddr[9:0]`, `extAddr[29:0]`.
  - outputs: `progress[9:0]`, `busy`.
- `ext` modport `IF_Mem.HOST`: external memory; `ADDR_LEN`=30, word addresses.
- `sram_ce` output 1: SRAM access enable.
- `sram_we` output 1: SRAM write enable; valid with `sram_ce`.
- `sram_id` output 1: selected cache, latched `cacheID`.
- `sram_addr` output 10: SRAM word address.
- `sram_wdata` output 32: SRAM write data.
- `sram_rdata` input 32: SRAM read data, valid the cycle after a read access.

## Operation
- Command accept: `ce && !busy` at a rising edge. The engine latches `we`, `cacheID`, `sramAddr` and `extAddr`, clears `progress` to 0 and sets `busy`. `ce` while `busy` is ignored.
- States: IDLE, WB, FILL.
  - IDLE to WB on accept with `we=1`; IDLE to FILL on accept with `we=0`.
  - WB or FILL to IDLE when `progress == LINE_WORDS`.
- Address generation for word k:
  - `sram_addr = sramAddr + k`, mod 2^10.
  - external address `= extAddr + k`, mod 2^30.
  - `ext.wmask` is always `4'b1111`.
- WB:
  - Issues SRAM reads k = 0..LINE_WORDS-1 in order. Read data enters a 2-entry word FIFO.
  - A new SRAM read is issued only when FIFO occupancy plus in-flight reads is less than 2.
  - `ext.we` is high whenever the FIFO is non-empty, with `wdata` = FIFO head and `waddr` = the next unwritten address.
  - A write is accepted when `ext.we && !ext.wbusy`; each acceptance increments `progress`.
- FILL:
  - Issues `ext.re` with `raddr` = next address until all LINE_WORDS reads are accepted. A read is accepted when `re && !rbusy`.
  - `ext.rdata` is valid exactly one cycle after acceptance. In that cycle the engine drives `sram_ce=1`, `sram_we=1`, `sram_wdata=ext.rdata`, and `progress` increments.
- `ext.re` and `ext.we` are never both high. Unused outputs are 0.
- `progress` holds its final value (LINE_WORDS) in IDLE until the next accept.
- Reset asserted, including mid-transfer: the transfer is aborted, state returns to IDLE, and all outputs go to 0 (`busy=0`, `progress=0`, `sram_ce=0`, `ext.we=0`, `ext.re=0`, addresses and data 0). There is no resume.

## Timing
- Cycle numbering: accept edge ends cycle 0.
- `busy=1` from cycle 1.
- WB, no stalls:
  - SRAM read k in cycle 1+k.
  - External write k in cycle 2+k.
  - Last write in cycle LINE_WORDS+1.
  - `busy=0` in cycle LINE_WORDS+2.
- FILL, no stalls:
  - External read k in cycle 1+k.
  - SRAM write k in cycle 2+k.
  - `busy=0` in cycle LINE_WORDS+2.
- Throughput is 1 word/cycle absent `rbusy`/`wbusy`. Each stall cycle delays completion by exactly one cycle. No word is lost or reordered.
- A new command asserted in the cycle `busy` first reads 0 is accepted at that edge: back-to-back gap of zero idle cycles.
- `progress` and `busy` are registered outputs.

## Structure
- Shared package (Include): state enum `MemCLineState {MLC_IDLE, MLC_WB, MLC_FILL}` and the default line length constant `MEMC_LINE_WORDS = 4`.
- Sub-module `memc_word_fifo`: 2-entry, 32-bit, push/pop/full/empty, asynchronous active-low reset; used for WB buffering.
- Counters: 10-bit issue index, 10-bit completion index (`progress`), 2-bit in-flight count.

## Test plan
- WB wrap:
  - Stimulus: `LINE_WORDS=4`, `sramAddr=0x3FE`, `extAddr=0x100`, no stalls.
  - Required response: SRAM reads at 0x3FE, 0x3FF, 0x000, 0x001; external writes at 0x100..0x103 in cycles 2..5 carrying that data; `busy` low in cycle 6; `progress=4`.
- FILL with stalls:
  - Stimulus: `extAddr=0x3FFFFFFE`, `rbusy` high in cycles 2–3.
  - Required response: `raddr` sequence 0x3FFFFFFE, 0x3FFFFFFF, 0x0, 0x1; SRAM writes with matching data in order; `busy` low in cycle 8.
- WB backpressure:
  - Stimulus: `wbusy` high in cycles 3–5.
  - Required response: at most 2 SRAM reads outstanding, all 4 words written in order, `busy` low in cycle 9.
- Busy collision: `ce` with new addresses in cycle 2 of a transfer -> ignored; the transfer completes with the original addresses.
- Reset mid-transfer: `rst=0` in cycle 3 of FILL -> all outputs 0 immediately; after release, a new WB command completes normally.
- Back-to-back: FILL then WB command applied in the first `busy=0` cycle -> WB accepted that edge; WB timing identical to the no-stall case.

Source files
------------

// File: rtl/memc_line_copy_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : memc_line_copy_pkg                                           |
// | Description : Shared types and constants for the cache line-copy engine.   |
// |               State encoding, default line length, FIFO occupancy helper.  |
// | Ports       : none (package)                                               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package memc_line_copy_pkg;

   typedef enum logic [1:0] {
      MLC_IDLE = 2'd0,
      MLC_WB   = 2'd1,
      MLC_FILL = 2'd2
   } MemCLineState;

   localparam int MEMC_LINE_WORDS = 4;

   // Occupancy of the 2-entry word FIFO, rebuilt from its full/empty flags.
   function automatic logic [1:0] fifo_occupancy(input logic full, input logic empty);
      if (full)       return 2'd2;
      else if (empty) return 2'd0;
      else            return 2'd1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/memc_word_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : memc_word_fifo                                               |
// | Description : 2-entry, 32-bit word FIFO. Simultaneous push and pop are     |
// |               allowed while not full; head is visible combinationally.     |
// | Ports       : clk_i, rst_n_i  - clock, async active-low reset              |
// |               push_i, wdata_i - write a word (ignored when full)           |
// |               pop_i           - drop the head word (ignored when empty)    |
// |               rdata_o         - head word                                  |
// |               full_o, empty_o - occupancy flags                            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module memc_word_fifo (
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic        push_i,
   input  logic        pop_i,
   input  logic [31:0] wdata_i,
   output logic [31:0] rdata_o,
   output logic        full_o,
   output logic        empty_o
);

   logic [31:0] mem_q [2];
   logic        wr_ptr_q;
   logic        rd_ptr_q;
   logic [1:0]  count_q;
   logic        do_push;
   logic        do_pop;

   assign full_o  = (count_q == 2'd2);
   assign empty_o = (count_q == 2'd0);
   assign rdata_o = mem_q[rd_ptr_q];
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         mem_q[0] <= 32'd0;
         mem_q[1] <= 32'd0;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
            wr_ptr_q        <= ~wr_ptr_q;
         end
         if (do_pop) begin
            rd_ptr_q <= ~rd_ptr_q;
         end
         count_q <= count_q + {1'b0, do_push} - {1'b0, do_pop};
      end
   end

endmodule
`default_nettype wire

// File: rtl/memc_line_copy.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : memc_line_copy                                               |
// | Description : Moves one cache line of LINE_WORDS 32-bit words between a    |
// |               cache SRAM and external memory. we=1 writeback (cache to     |
// |               external), we=0 fill (external to cache).                    |
// | Ports       : clk_i, rst_n_i     - clock, async active-low reset           |
// |               memc_*_i / memc_*_o - command in, progress/busy out          |
// |               ext_*              - external memory host port (word addr)   |
// |               sram_*             - cache SRAM port (1-cycle read latency)  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module memc_line_copy
   import memc_line_copy_pkg::*;
#(
   parameter int LINE_WORDS = MEMC_LINE_WORDS
) (
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic        memc_ce_i,
   input  logic        memc_we_i,
   input  logic        memc_cache_id_i,
   input  logic [9:0]  memc_sram_addr_i,
   input  logic [29:0] memc_ext_addr_i,
   output logic [9:0]  memc_progress_o,
   output logic        memc_busy_o,
   output logic        ext_re_o,
   output logic [29:0] ext_raddr_o,
   input  logic [31:0] ext_rdata_i,
   input  logic        ext_rbusy_i,
   output logic        ext_we_o,
   output logic [29:0] ext_waddr_o,
   output logic [31:0] ext_wdata_o,
   output logic [3:0]  ext_wmask_o,
   input  logic        ext_wbusy_i,
   output logic        sram_ce_o,
   output logic        sram_we_o,
   output logic        sram_id_o,
   output logic [9:0]  sram_addr_o,
   output logic [31:0] sram_wdata_o,
   input  logic [31:0] sram_rdata_i
);

   localparam logic [9:0] LW = 10'(LINE_WORDS);

   MemCLineState state_q, state_d;
   logic        busy_q, busy_d;
   logic [9:0]  progress_q, progress_d;
   logic [9:0]  issue_q, issue_d;
   logic [1:0]  inflight_q, inflight_d;
   logic        fill_pend_q, fill_pend_d;
   logic        cache_id_q, cache_id_d;
   logic [9:0]  sram_base_q, sram_base_d;
   logic [29:0] ext_base_q, ext_base_d;

   logic        fifo_push, fifo_pop, fifo_full, fifo_empty;
   logic [31:0] fifo_rdata;
   logic [2:0]  wb_pending;
   logic        wr_acc;

   memc_word_fifo u_fifo (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .push_i  (fifo_push),
      .pop_i   (fifo_pop),
      .wdata_i (sram_rdata_i),
      .rdata_o (fifo_rdata),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   // Words buffered plus SRAM reads whose data lands this cycle.
   assign wb_pending = {1'b0, fifo_occupancy(fifo_full, fifo_empty)} + {1'b0, inflight_q};

   always_comb begin
      state_d      = state_q;
      busy_d       = busy_q;
      progress_d   = progress_q;
      issue_d      = issue_q;
      inflight_d   = 2'd0;
      fill_pend_d  = 1'b0;
      cache_id_d   = cache_id_q;
      sram_base_d  = sram_base_q;
      ext_base_d   = ext_base_q;
      fifo_push    = 1'b0;
      fifo_pop     = 1'b0;
      wr_acc       = 1'b0;
      sram_ce_o    = 1'b0;
      sram_we_o    = 1'b0;
      sram_id_o    = 1'b0;
      sram_addr_o  = 10'd0;
      sram_wdata_o = 32'd0;
      ext_re_o     = 1'b0;
      ext_raddr_o  = 30'd0;
      ext_we_o     = 1'b0;
      ext_waddr_o  = 30'd0;
      ext_wdata_o  = 32'd0;
      ext_wmask_o  = 4'd0;

      unique case (state_q)
         MLC_IDLE: begin
            if (memc_ce_i) begin
               cache_id_d  = memc_cache_id_i;
               sram_base_d = memc_sram_addr_i;
               ext_base_d  = memc_ext_addr_i;
               progress_d  = 10'd0;
               issue_d     = 10'd0;
               busy_d      = 1'b1;
               state_d     = memc_we_i ? MLC_WB : MLC_FILL;
            end
         end

         MLC_WB: begin
            if ((issue_q < LW) && (wb_pending < 3'd2)) begin
               sram_ce_o   = 1'b1;
               sram_id_o   = cache_id_q;
               sram_addr_o = sram_base_q + issue_q;
               issue_d     = issue_q + 10'd1;
               inflight_d  = 2'd1;
            end
            // Arriving SRAM data bypasses the empty FIFO so the first write
            // goes out the cycle after the first read.
            if (!fifo_empty || (inflight_q != 2'd0)) begin
               ext_we_o    = 1'b1;
               ext_waddr_o = ext_base_q + {20'd0, progress_q};
               ext_wdata_o = fifo_empty ? sram_rdata_i : fifo_rdata;
               ext_wmask_o = 4'hF;
            end
            wr_acc    = ext_we_o && !ext_wbusy_i;
            fifo_push = (inflight_q != 2'd0) && !(fifo_empty && wr_acc);
            fifo_pop  = !fifo_empty && wr_acc;
            if (wr_acc) begin
               progress_d = progress_q + 10'd1;
               if (progress_q == LW - 10'd1) begin
                  state_d = MLC_IDLE;
                  busy_d  = 1'b0;
               end
            end
         end

         MLC_FILL: begin
            if (issue_q < LW) begin
               ext_re_o    = 1'b1;
               ext_raddr_o = ext_base_q + {20'd0, issue_q};
               if (!ext_rbusy_i) begin
                  issue_d     = issue_q + 10'd1;
                  fill_pend_d = 1'b1;
               end
            end
            // Read data from the previous cycle's accepted request.
            if (fill_pend_q) begin
               sram_ce_o    = 1'b1;
               sram_we_o    = 1'b1;
               sram_id_o    = cache_id_q;
               sram_addr_o  = sram_base_q + progress_q;
               sram_wdata_o = ext_rdata_i;
               progress_d   = progress_q + 10'd1;
               if (progress_q == LW - 10'd1) begin
                  state_d = MLC_IDLE;
                  busy_d  = 1'b0;
               end
            end
         end

         default: begin
            state_d = MLC_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q     <= MLC_IDLE;
         busy_q      <= 1'b0;
         progress_q  <= 10'd0;
         issue_q     <= 10'd0;
         inflight_q  <= 2'd0;
         fill_pend_q <= 1'b0;
         cache_id_q  <= 1'b0;
         sram_base_q <= 10'd0;
         ext_base_q  <= 30'd0;
      end else begin
         state_q     <= state_d;
         busy_q      <= busy_d;
         progress_q  <= progress_d;
         issue_q     <= issue_d;
         inflight_q  <= inflight_d;
         fill_pend_q <= fill_pend_d;
         cache_id_q  <= cache_id_d;
         sram_base_q <= sram_base_d;
         ext_base_q  <= ext_base_d;
      end
   end

   assign memc_busy_o     = busy_q;
   assign memc_progress_o = progress_q;

endmodule
`default_nettype wire

// File: tb/tb_memc_line_copy.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_memc_line_copy                                            |
// | Description : Self-checking bench for memc_line_copy. Table of commands    |
// |               with stall masks and expected completion cycle; scoreboard   |
// |               of expected words filled when a command is issued.           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_memc_line_copy;

   localparam int LW = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        ce, cmd_we, cmd_id;
   logic [9:0]  cmd_saddr;
   logic [29:0] cmd_eaddr;
   logic [9:0]  progress;
   logic        busy;
   logic        ext_re, ext_we, ext_rbusy, ext_wbusy;
   logic [29:0] ext_raddr, ext_waddr;
   logic [31:0] ext_rdata, ext_wdata;
   logic [3:0]  ext_wmask;
   logic        sram_ce, sram_we, sram_id;
   logic [9:0]  sram_addr;
   logic [31:0] sram_wdata, sram_rdata;

   always #5 clk = ~clk;

   memc_line_copy #(.LINE_WORDS(LW)) dut (
      .clk_i           (clk),
      .rst_n_i         (rst_n),
      .memc_ce_i       (ce),
      .memc_we_i       (cmd_we),
      .memc_cache_id_i (cmd_id),
      .memc_sram_addr_i(cmd_saddr),
      .memc_ext_addr_i (cmd_eaddr),
      .memc_progress_o (progress),
      .memc_busy_o     (busy),
      .ext_re_o        (ext_re),
      .ext_raddr_o     (ext_raddr),
      .ext_rdata_i     (ext_rdata),
      .ext_rbusy_i     (ext_rbusy),
      .ext_we_o        (ext_we),
      .ext_waddr_o     (ext_waddr),
      .ext_wdata_o     (ext_wdata),
      .ext_wmask_o     (ext_wmask),
      .ext_wbusy_i     (ext_wbusy),
      .sram_ce_o       (sram_ce),
      .sram_we_o       (sram_we),
      .sram_id_o       (sram_id),
      .sram_addr_o     (sram_addr),
      .sram_wdata_o    (sram_wdata),
      .sram_rdata_i    (sram_rdata)
   );

   function automatic logic [31:0] sram_pat(input logic [9:0] a);
      return {6'h2A, a, 6'h15, a};
   endfunction

   function automatic logic [31:0] ext_pat(input logic [29:0] a);
      return {a, 2'b01} ^ 32'hC3C3_0000;
   endfunction

   // Memory models: SRAM read data and external read data one cycle later.
   always @(posedge clk) begin
      if (sram_ce && !sram_we) sram_rdata <= sram_pat(sram_addr);
      if (ext_re && !ext_rbusy) ext_rdata <= ext_pat(ext_raddr);
   end

   typedef struct {
      logic        we;
      logic        id;
      logic [9:0]  saddr;
      logic [29:0] eaddr;
      logic [15:0] rb;
      logic [15:0] wb;
      int          done;
      logic        coll;
   } vec_t;

   typedef struct packed {
      logic [29:0] addr;
      logic [31:0] data;
   } xfer_t;

   xfer_t       exp_q[$];
   logic [29:0] adr_q[$];
   vec_t        vecs[8];
   vec_t        tmp;
   int          n_vec = 0;
   int          n_err = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk); #2;
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_busy_progress"}, {21'd0, busy, progress}, 32'd0);
      chk({tag, "_sram_ctl"}, {19'd0, sram_ce, sram_we, sram_id, sram_addr}, 32'd0);
      chk({tag, "_sram_wdata"}, sram_wdata, 32'd0);
      chk({tag, "_ext_ctl"}, {26'd0, ext_re, ext_we, ext_wmask}, 32'd0);
      chk({tag, "_ext_raddr"}, {2'd0, ext_raddr}, 32'd0);
      chk({tag, "_ext_waddr"}, {2'd0, ext_waddr}, 32'd0);
      chk({tag, "_ext_wdata"}, ext_wdata, 32'd0);
   endtask

   // Entered at 2 time units after a rising edge (cycle 0 of the command).
   task automatic run_cmd(input vec_t v);
      xfer_t       e;
      logic [9:0]  sa;
      logic [29:0] ea, a;
      int          reads, k, maxout;
      bit          done, both;
      exp_q.delete();
      adr_q.delete();
      for (int i = 0; i < LW; i++) begin
         sa = v.saddr + 10'(i);
         ea = v.eaddr + 30'(i);
         if (v.we) begin
            e.addr = ea; e.data = sram_pat(sa); a = {20'd0, sa};
         end else begin
            e.addr = {20'd0, sa}; e.data = ext_pat(ea); a = ea;
         end
         exp_q.push_back(e);
         adr_q.push_back(a);
      end
      reads = 0; k = 0; maxout = 0; done = 0; both = 0;
      chk("busy_before_accept", {31'd0, busy}, 32'd0);
      ce = 1'b1; cmd_we = v.we; cmd_id = v.id; cmd_saddr = v.saddr; cmd_eaddr = v.eaddr;
      for (int c = 1; c <= v.done + 20 && !done; c++) begin
         @(posedge clk); #1;
         ce        = 1'b0;
         ext_rbusy = (c < 16) ? v.rb[c] : 1'b0;
         ext_wbusy = (c < 16) ? v.wb[c] : 1'b0;
         if (v.coll && c == 2) begin
            ce = 1'b1; cmd_we = ~v.we; cmd_id = ~v.id;
            cmd_saddr = v.saddr + 10'h155; cmd_eaddr = v.eaddr + 30'h777;
         end
         #1;
         if (!busy) begin
            chk("done_cycle", c, v.done);
            done = 1;
         end else begin
            if (ext_re && ext_we) both = 1;
            if ((sram_ce && !sram_we) || (ext_re && !ext_rbusy)) begin
               a = (adr_q.size() == 0) ? '1 : adr_q.pop_front();
               if (sram_ce && !sram_we) begin
                  reads++;
                  chk("sram_raddr", {22'd0, sram_addr}, {2'd0, a});
                  chk("sram_rd_id", {31'd0, sram_id}, {31'd0, v.id});
               end else begin
                  chk("ext_raddr", {2'd0, ext_raddr}, {2'd0, a});
               end
            end
            if ((ext_we && !ext_wbusy) || (sram_ce && sram_we)) begin
               e = (exp_q.size() == 0) ? '1 : exp_q.pop_front();
               chk("progress_at_word", {22'd0, progress}, k);
               if (ext_we) begin
                  chk("ext_waddr", {2'd0, ext_waddr}, {2'd0, e.addr});
                  chk("ext_wdata", ext_wdata, e.data);
                  chk("ext_wmask", {28'd0, ext_wmask}, 32'hF);
               end else begin
                  chk("sram_waddr", {22'd0, sram_addr}, {2'd0, e.addr});
                  chk("sram_wdata", sram_wdata, e.data);
                  chk("sram_wr_id", {31'd0, sram_id}, {31'd0, v.id});
               end
               k++;
            end
            if (reads - k > maxout) maxout = reads - k;
         end
      end
      ext_rbusy = 1'b0;
      ext_wbusy = 1'b0;
      chk("busy_fell", {31'd0, done}, 32'd1);
      chk("words_moved", k, LW);
      chk("scoreboard_empty", exp_q.size(), 0);
      chk("progress_final", {22'd0, progress}, LW);
      chk("re_we_exclusive", {31'd0, both}, 32'd0);
      if (v.we) chk("outstanding_le2", (maxout <= 2) ? 32'd1 : 32'd0, 32'd1);
   endtask

   initial begin
      rst_n = 1'b0; ce = 1'b0; cmd_we = 1'b0; cmd_id = 1'b0;
      cmd_saddr = '0; cmd_eaddr = '0; ext_rbusy = 1'b0; ext_wbusy = 1'b0;
      sram_rdata = '0; ext_rdata = '0;

      //          we    id    saddr    eaddr           rbusy     wbusy     done coll
      vecs[0] = '{1'b1, 1'b0, 10'h3FE, 30'h100,       16'h0000, 16'h0000, 6, 1'b0}; // WB wrap
      vecs[1] = '{1'b0, 1'b1, 10'h010, 30'h3FFFFFFE,  16'h000C, 16'h0000, 8, 1'b0}; // FILL stalls
      vecs[2] = '{1'b1, 1'b1, 10'h020, 30'h200,       16'h0000, 16'h0038, 9, 1'b0}; // WB backpressure
      vecs[3] = '{1'b0, 1'b0, 10'h3FD, 30'h12345,     16'h0000, 16'h0000, 6, 1'b0}; // FILL plain
      vecs[4] = '{1'b1, 1'b0, 10'h040, 30'h300,       16'h0000, 16'h0000, 6, 1'b1}; // WB collision
      vecs[5] = '{1'b0, 1'b1, 10'h080, 30'h3000,      16'h0000, 16'h0000, 6, 1'b1}; // FILL collision
      vecs[6] = '{1'b1, 1'b1, 10'h1F0, 30'h3FFFFFFF,  16'h0000, 16'h0004, 7, 1'b0}; // WB first-write stall
      vecs[7] = '{1'b0, 1'b0, 10'h2AA, 30'h5555,      16'h0002, 16'h0000, 7, 1'b0}; // FILL first-read stall

      repeat (2) @(posedge clk);
      #2;
      chk_zero("reset");
      rst_n = 1'b1;
      idle(1);

      for (int i = 0; i < 8; i++) begin
         run_cmd(vecs[i]);
         idle(2);
         chk("progress_hold", {22'd0, progress}, LW);
      end

      // Back-to-back: WB issued in the first cycle busy reads 0 after a FILL.
      run_cmd(vecs[3]);
      run_cmd(vecs[0]);
      idle(2);

      // Reset in cycle 3 of a FILL, then a normal WB.
      ce = 1'b1; cmd_we = 1'b0; cmd_id = 1'b1; cmd_saddr = 10'h123; cmd_eaddr = 30'h4444;
      @(posedge clk); #1; ce = 1'b0; #1;
      chk("fill_started", {31'd0, busy}, 32'd1);
      @(posedge clk); #2;
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      chk_zero("reset_mid");
      @(posedge clk); #1;
      rst_n = 1'b1;
      #1;
      idle(1);
      tmp = vecs[2];
      tmp.wb = 16'h0;
      tmp.done = 6;
      run_cmd(tmp);
      idle(2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
